// File: rtl/multi_cycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences the shared
// datapath (single memory, single ALU, IR/MDR/A/B/ALUOut) for R-type,
// lw, sw, beq and j. Memory-access states stall on mem_ready.
module multi_cycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter bit         WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_MWB = 4'd4,
        S_MW  = 4'd5,
        S_EX  = 4'd6,
        S_RWB = 4'd7,
        S_BR  = 4'd8,
        S_JP  = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_OUT   = 2'b01;
    localparam logic [1:0] PCS_JUMP  = 2'b10;

    state_t state_q;
    state_t state_d;
    logic   rdy;

    // Memory handshake; with WAIT_MEM=0 every access completes in one cycle
    assign rdy   = mem_ready | ~WAIT_MEM;
    assign state = state_q;

    // State register; reset drops straight back to instruction fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; only rdy-qualified enables see mem_ready
    always_comb begin
        state_d       = S_IF;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            S_ID: begin
                // Precompute the branch target while the opcode is decoded
                alu_src_a = 1'b0;
                alu_src_b = SRCB_IMM2;
                alu_op    = ALU_ADD;
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MA;
                end else if (op == OP_RTYPE) begin
                    state_d = S_EX;
                end else if (op == OP_BEQ) begin
                    state_d = S_BR;
                end else if (op == OP_J) begin
                    state_d = S_JP;
                end else begin
                    state_d    = S_IF;
                    illegal_op = 1'b1;
                end
            end

            S_MA: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (op == OP_SW) ? S_MW : S_MR;
            end

            S_MR: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = rdy ? S_MWB : S_MR;
            end

            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                instr_done = 1'b1;
                state_d    = S_IF;
            end

            S_MW: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = rdy;
                state_d    = rdy ? S_IF : S_MW;
            end

            S_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_FUNCT;
                state_d   = S_RWB;
            end

            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
                state_d    = S_IF;
            end

            S_BR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_OUT;
                instr_done    = 1'b1;
                state_d       = S_IF;
            end

            S_JP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                instr_done = 1'b1;
                state_d    = S_IF;
            end

            default: begin
                // Instruction fetch (also covers the unused codes 10-15)
                i_or_d    = 1'b0;
                mem_read  = 1'b1;
                alu_src_a = 1'b0;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                pc_source = PCS_ALU;
                ir_write  = rdy;
                pc_write  = rdy;
                state_d   = rdy ? S_ID : S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: random instruction mix with
// random memory stalls, expected per-instruction behaviour queued by the
// stimulus and checked by an independent monitor on each completion.
module tb_multi_cycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    multi_cycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] trace;
        int          ncyc;
        int          n_ir;
        int          n_pcw;
        int          n_rw;
        int          n_mw;
        int          n_mr;
        int          n_pcc;
        logic [1:0]  wb;
        logic [1:0]  pcs;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus, inputs change just after the rising edge
    task automatic drive(input logic [5:0] o, input logic mr);
        op        = o;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
               (o == 6'b000100) || (o == 6'b000010);
    endfunction

    // Monitor: accumulate per-instruction observations, check on completion
    logic [63:0] m_trace;
    int m_ncyc, m_ir, m_pcw, m_rw, m_mw, m_mr, m_pcc, m_bad;
    logic [1:0] m_wb, m_pcs;

    task automatic mon_clear();
        m_trace = 64'd0; m_ncyc = 0; m_ir = 0; m_pcw = 0; m_rw = 0;
        m_mw = 0; m_mr = 0; m_pcc = 0; m_bad = 0; m_wb = 2'b00; m_pcs = 2'b00;
    endtask

    initial mon_clear();

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            m_trace = (m_trace << 4) | 64'(state);
            m_ncyc++;
            if (ir_write)      m_ir++;
            if (pc_write)      m_pcw++;
            if (reg_write)     m_rw++;
            if (mem_write)     m_mw++;
            if (mem_read)      m_mr++;
            if (pc_write_cond) m_pcc++;
            if (reg_write)                 m_wb  = {mem_to_reg, reg_dst};
            if (pc_write || pc_write_cond) m_pcs = pc_source;
            // Datapath selects that each state must present
            case (state)
                4'd0: if (i_or_d || alu_src_a || alu_src_b != 2'b01 || alu_op != 2'b00) m_bad++;
                4'd1: if (alu_src_a || alu_src_b != 2'b11 || alu_op != 2'b00) m_bad++;
                4'd2: if (!alu_src_a || alu_src_b != 2'b10 || alu_op != 2'b00) m_bad++;
                4'd3: if (!i_or_d || !mem_read || mem_write) m_bad++;
                4'd5: if (!i_or_d || !mem_write || mem_read) m_bad++;
                4'd6: if (!alu_src_a || alu_src_b != 2'b00 || alu_op != 2'b10) m_bad++;
                4'd8: if (!alu_src_a || alu_src_b != 2'b00 || alu_op != 2'b01) m_bad++;
                default: ;
            endcase
            if (instr_done || illegal_op) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("state_trace", m_trace, e.trace);
                    chk("cycles", 64'(m_ncyc), 64'(e.ncyc));
                    chk("ir_write_cnt", 64'(m_ir), 64'(e.n_ir));
                    chk("pc_write_cnt", 64'(m_pcw), 64'(e.n_pcw));
                    chk("reg_write_cnt", 64'(m_rw), 64'(e.n_rw));
                    chk("mem_write_cnt", 64'(m_mw), 64'(e.n_mw));
                    chk("mem_read_cnt", 64'(m_mr), 64'(e.n_mr));
                    chk("pc_write_cond_cnt", 64'(m_pcc), 64'(e.n_pcc));
                    chk("wb_select", 64'(m_wb), 64'(e.wb));
                    chk("pc_source", 64'(m_pcs), 64'(e.pcs));
                    chk("illegal_flag", 64'(illegal_op), 64'(e.illegal));
                    chk("done_flag", 64'(instr_done), 64'(!e.illegal));
                    chk("select_errors", 64'(m_bad), 64'd0);
                end
                mon_clear();
            end
        end
    end

    // Reference model: builds the expected record and drives one instruction
    task automatic run_instr(input int kind, input logic [5:0] o, input int s_if, input int s_mem);
        exp_t e;
        int   seq[$];
        int   nif;
        e.trace = 64'd0;
        for (int i = 0; i <= s_if; i++) seq.push_back(0);
        seq.push_back(1);
        case (kind)
            0: begin seq.push_back(2); for (int i = 0; i <= s_mem; i++) seq.push_back(3); seq.push_back(4); end
            1: begin seq.push_back(2); for (int i = 0; i <= s_mem; i++) seq.push_back(5); end
            2: begin seq.push_back(6); seq.push_back(7); end
            3: seq.push_back(8);
            4: seq.push_back(9);
            default: ;
        endcase
        foreach (seq[i]) e.trace = (e.trace << 4) | 64'(seq[i]);
        e.ncyc    = seq.size();
        e.n_ir    = 1;
        e.n_pcw   = (kind == 4) ? 2 : 1;
        e.n_rw    = (kind == 0 || kind == 2) ? 1 : 0;
        e.n_mw    = (kind == 1) ? s_mem + 1 : 0;
        e.n_mr    = s_if + 1 + ((kind == 0) ? s_mem + 1 : 0);
        e.n_pcc   = (kind == 3) ? 1 : 0;
        e.wb      = (kind == 0) ? 2'b10 : (kind == 2) ? 2'b01 : 2'b00;
        e.pcs     = (kind == 4) ? 2'b10 : (kind == 3) ? 2'b01 : 2'b00;
        e.illegal = (kind == 5);
        exp_q.push_back(e);

        // Drive: opcode is don't-care in fetch, held from decode onward;
        // mem_ready is random wherever the control must ignore it
        nif = 0;
        foreach (seq[i]) begin
            logic mr;
            logic [5:0] oc;
            mr = 1'($urandom);
            oc = o;
            if (seq[i] == 0) begin
                oc = 6'($urandom);
                mr = (nif == s_if);
                nif++;
            end else if (seq[i] == 3 || seq[i] == 5) begin
                mr = (i == seq.size() - 1 - ((kind == 0) ? 1 : 0));
            end
            drive(oc, mr);
        end
    endtask

    initial begin
        logic [5:0] lut[5];
        lut[0] = 6'b100011; lut[1] = 6'b101011; lut[2] = 6'b000000;
        lut[3] = 6'b000100; lut[4] = 6'b000010;

        rst_n = 1'b1;
        op = 6'd0;
        mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_mem_read", 64'(mem_read), 64'd1);
        chk("reset_instr_done", 64'(instr_done), 64'd0);
        chk("reset_illegal_op", 64'(illegal_op), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // lw into the read stall, then abort with reset mid-cycle
        drive(6'b100011, 1'b1);
        drive(6'b100011, 1'b1);
        drive(6'b100011, 1'b1);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("pre_abort_state", 64'(state), 64'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_ir_write", 64'(ir_write), 64'd0);
        chk("abort_instr_done", 64'(instr_done), 64'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_reg_write", 64'(reg_write), 64'd0);
            chk("abort_hold_state", 64'(state), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed: stalled lw (3 fetch stalls, 2 read stalls) and illegal opcode
        run_instr(0, lut[0], 3, 2);
        run_instr(5, 6'b111111, 0, 0);
        for (int k = 0; k < 5; k++) run_instr(k, lut[k], 0, 0);

        // Random mix
        for (int n = 0; n < 200; n++) begin
            int kind;
            logic [5:0] o;
            kind = $urandom_range(0, 5);
            if (kind == 5) begin
                o = 6'($urandom);
                while (is_legal(o)) o = 6'($urandom);
            end else begin
                o = lut[kind];
            end
            run_instr(kind, o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        mon_en = 1'b0;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
